// File: rtl/vga_pkg.sv
// Shared VGA definitions: default geometry, bar colours and pattern encodings.
package vga_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_COORD_W  = 10;

    // Colour bars, left to right, as {R,G,B} nibbles
    localparam logic [11:0] BAR_WHITE   = 12'hFFF;
    localparam logic [11:0] BAR_YELLOW  = 12'hFF0;
    localparam logic [11:0] BAR_CYAN    = 12'h0FF;
    localparam logic [11:0] BAR_GREEN   = 12'h0F0;
    localparam logic [11:0] BAR_MAGENTA = 12'hF0F;
    localparam logic [11:0] BAR_RED     = 12'hF00;
    localparam logic [11:0] BAR_BLUE    = 12'h00F;
    localparam logic [11:0] BAR_BLACK   = 12'h000;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_BOX   = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_SOLID = 2'd3
    } pattern_e;

    function automatic logic [11:0] bar_color(input logic [2:0] idx);
        logic [11:0] c;
        unique case (idx)
            3'd0: c = BAR_WHITE;
            3'd1: c = BAR_YELLOW;
            3'd2: c = BAR_CYAN;
            3'd3: c = BAR_GREEN;
            3'd4: c = BAR_MAGENTA;
            3'd5: c = BAR_RED;
            3'd6: c = BAR_BLUE;
            3'd7: c = BAR_BLACK;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position state: advances one step per axis on each frame tick.
module vga_box_mover
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned COORD_W  = DEF_COORD_W,
    parameter int unsigned BOX_SIZE = 32,
    parameter int unsigned STEP     = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    output logic [COORD_W-1:0] box_x,
    output logic [COORD_W-1:0] box_y
);

    typedef logic [COORD_W-1:0] coord_t;
    // One extra bit so pos + BOX_SIZE + STEP cannot wrap
    typedef logic [COORD_W:0]   ext_t;

    localparam coord_t StepC    = coord_t'(STEP);
    localparam ext_t   SizeStep = ext_t'(BOX_SIZE + STEP);
    localparam ext_t   ExtentX  = ext_t'(H_ACTIVE);
    localparam ext_t   ExtentY  = ext_t'(V_ACTIVE);

    coord_t box_x_q, box_x_d, box_y_q, box_y_d;
    logic   dir_x_q, dir_x_d, dir_y_q, dir_y_d;   // 1 = increasing

    // Bounce logic: reverse and step back when the next step would cross an edge
    always_comb begin
        box_x_d = box_x_q;
        box_y_d = box_y_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        if (tick) begin
            if (dir_x_q) begin
                if (ext_t'(box_x_q) + SizeStep > ExtentX) begin
                    dir_x_d = 1'b0;
                    box_x_d = box_x_q - StepC;
                end else begin
                    box_x_d = box_x_q + StepC;
                end
            end else if (box_x_q < StepC) begin
                dir_x_d = 1'b1;
                box_x_d = box_x_q + StepC;
            end else begin
                box_x_d = box_x_q - StepC;
            end

            if (dir_y_q) begin
                if (ext_t'(box_y_q) + SizeStep > ExtentY) begin
                    dir_y_d = 1'b0;
                    box_y_d = box_y_q - StepC;
                end else begin
                    box_y_d = box_y_q + StepC;
                end
            end else if (box_y_q < StepC) begin
                dir_y_d = 1'b1;
                box_y_d = box_y_q + StepC;
            end else begin
                box_y_d = box_y_q - StepC;
            end
        end
    end

    // Position and direction registers
    always_ff @(posedge clk) begin
        if (reset) begin
            box_x_q <= '0;
            box_y_q <= '0;
            dir_x_q <= 1'b1;
            dir_y_q <= 1'b1;
        end else begin
            box_x_q <= box_x_d;
            box_y_q <= box_y_d;
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
        end
    end

    assign box_x = box_x_q;
    assign box_y = box_y_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel source: renders bars/box/checker/solid and re-aligns syncs.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter int unsigned COORD_W    = DEF_COORD_W,
    parameter int unsigned BOX_SIZE   = 32,
    parameter int unsigned STEP       = 1,
    parameter int unsigned CHECK_LOG2 = 5,
    parameter logic [11:0] BG_COLOR   = 12'h222
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    input  logic               video_on_in,
    input  logic               h_sync_in,
    input  logic               v_sync_in,
    input  logic [1:0]         pattern_sel,
    input  logic [11:0]        color,
    output logic [11:0]        rgb,
    output logic               video_on_out,
    output logic               h_sync_out,
    output logic               v_sync_out,
    output logic               frame_tick
);

    typedef logic [COORD_W:0] ext_t;

    localparam ext_t SizeExt = ext_t'(BOX_SIZE);

    logic [COORD_W-1:0] box_x, box_y;
    logic               eof;
    logic [2:0]         bar_idx;
    logic               in_box;
    logic [11:0]        pix_color;
    pattern_e           sel;

    logic [11:0] rgb_q;
    logic        video_on_q, h_sync_q, v_sync_q, frame_tick_q;

    vga_box_mover #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .COORD_W  (COORD_W),
        .BOX_SIZE (BOX_SIZE),
        .STEP     (STEP)
    ) u_box_mover (
        .clk   (clk),
        .reset (reset),
        .tick  (frame_tick_q),
        .box_x (box_x),
        .box_y (box_y)
    );

    assign eof = video_on_in && (32'(pos_x) == H_ACTIVE - 1) && (32'(pos_y) == V_ACTIVE - 1);
    assign sel = pattern_e'(pattern_sel);

    // Bar index: number of bar thresholds at or left of pos_x
    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (32'(pos_x) >= (k * H_ACTIVE) / 8) begin
                bar_idx = 3'(k);
            end
        end
    end

    assign in_box = (ext_t'(pos_x) >= ext_t'(box_x))
                 && (ext_t'(pos_x) <  ext_t'(box_x) + SizeExt)
                 && (ext_t'(pos_y) >= ext_t'(box_y))
                 && (ext_t'(pos_y) <  ext_t'(box_y) + SizeExt);

    // Pattern mux for the current pixel
    always_comb begin
        pix_color = 12'h000;
        unique case (sel)
            PAT_BARS:  pix_color = bar_color(bar_idx);
            PAT_BOX:   pix_color = in_box ? color : BG_COLOR;
            PAT_CHECK: pix_color = (pos_x[CHECK_LOG2] ^ pos_y[CHECK_LOG2]) ? 12'hFFF : 12'h000;
            PAT_SOLID: pix_color = color;
            default:   pix_color = 12'h000;
        endcase
    end

    // Output pipeline: colour, video_on and syncs stay mutually aligned
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q        <= 12'h000;
            video_on_q   <= 1'b0;
            h_sync_q     <= 1'b1;
            v_sync_q     <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            rgb_q        <= video_on_in ? pix_color : 12'h000;
            video_on_q   <= video_on_in;
            h_sync_q     <= h_sync_in;
            v_sync_q     <= v_sync_in;
            frame_tick_q <= eof;
        end
    end

    assign rgb          = rgb_q;
    assign video_on_out = video_on_q;
    assign h_sync_out   = h_sync_q;
    assign v_sync_out   = v_sync_q;
    assign frame_tick   = frame_tick_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: directed and random pixels against a frame-count model.
module tb_vga_pattern_gen;

    localparam int HA = 640;
    localparam int VA = 480;
    localparam int BS = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  pos_x, pos_y;
    logic        video_on_in, h_sync_in, v_sync_in;
    logic [1:0]  pattern_sel;
    logic [11:0] color;
    logic [11:0] rgb;
    logic        video_on_out, h_sync_out, v_sync_out, frame_tick;

    int checks = 0;
    int errors = 0;

    // Model state: ticks applied to the box so far, and whether a tick is due
    int n_ticks  = 0;
    bit tick_due = 0;

    logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                              12'hF0F, 12'hF00, 12'h00F, 12'h000};

    always #5 clk = ~clk;

    vga_pattern_gen dut (
        .clk          (clk),
        .reset        (reset),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .video_on_in  (video_on_in),
        .h_sync_in    (h_sync_in),
        .v_sync_in    (v_sync_in),
        .pattern_sel  (pattern_sel),
        .color        (color),
        .rgb          (rgb),
        .video_on_out (video_on_out),
        .h_sync_out   (h_sync_out),
        .v_sync_out   (v_sync_out),
        .frame_tick   (frame_tick)
    );

    // Box position after n ticks is a triangle wave of period 2*range
    function automatic int tri_pos(input int n, input int range);
        int m;
        m = n % (2 * range);
        return (m <= range) ? m : 2 * range - m;
    endfunction

    function automatic int box_x_model();
        return tri_pos(n_ticks, HA - BS);
    endfunction

    function automatic int box_y_model();
        return tri_pos(n_ticks, VA - BS);
    endfunction

    function automatic logic [11:0] model_pix(input int x, input int y, input int pat,
                                              input logic [11:0] col);
        int bx, by;
        bx = box_x_model();
        by = box_y_model();
        case (pat)
            0: return bars[(x * 8) / HA];
            1: return (x >= bx && x < bx + BS && y >= by && y < by + BS) ? col : 12'h222;
            2: return (((x / 32) + (y / 32)) % 2 == 1) ? 12'hFFF : 12'h000;
            default: return col;
        endcase
    endfunction

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (ticks=%0d)", tag, obs, exp, n_ticks);
        end
    endtask

    // One pixel: drive at a falling edge, check outputs at the next falling edge
    task automatic step(input bit rst, input int x, input int y, input bit von,
                        input bit hs, input bit vs, input int pat, input logic [11:0] col,
                        input string tag);
        logic [11:0] exp_rgb;
        bit          exp_tick;
        reset       = rst;
        pos_x       = 10'(x);
        pos_y       = 10'(y);
        video_on_in = von;
        h_sync_in   = hs;
        v_sync_in   = vs;
        pattern_sel = 2'(pat);
        color       = col;
        exp_rgb     = (rst || !von) ? 12'h000 : model_pix(x, y, pat, col);
        exp_tick    = !rst && von && x == HA - 1 && y == VA - 1;
        @(negedge clk);
        check({tag, ".rgb"}, rgb, exp_rgb);
        check({tag, ".von"}, 12'(video_on_out), rst ? 12'h0 : 12'(von));
        check({tag, ".hs"}, 12'(h_sync_out), rst ? 12'h1 : 12'(hs));
        check({tag, ".vs"}, 12'(v_sync_out), rst ? 12'h1 : 12'(vs));
        check({tag, ".tick"}, 12'(frame_tick), 12'(exp_tick));
        if (rst) begin
            n_ticks  = 0;
            tick_due = 0;
        end else begin
            if (tick_due) n_ticks++;
            tick_due = exp_tick;
        end
    endtask

    task automatic rand_pixel(input string tag);
        step(0, $urandom_range(HA - 1), $urandom_range(VA - 1), ($urandom_range(7) != 0),
             1'($urandom), 1'($urandom), $urandom_range(3), 12'($urandom), tag);
    endtask

    // Last active pixel followed by one blanking cycle
    task automatic end_frame();
        step(0, HA - 1, VA - 1, 1, 1'($urandom), 1'($urandom), $urandom_range(3),
             12'($urandom), "eof");
        step(0, HA, VA - 1, 0, 0, 1, $urandom_range(3), 12'($urandom), "blank");
    endtask

    // Box-mode pixels around the modelled box corners
    task automatic probe_box(input string tag);
        int bx, by, x, y;
        int offs [4] = '{-1, 0, BS - 1, BS};
        bx = box_x_model();
        by = box_y_model();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                x = bx + offs[i];
                y = by + offs[j];
                if (x >= 0 && x < HA && y >= 0 && y < VA && !(x == HA - 1 && y == VA - 1))
                    step(0, x, y, 1, 1, 1, 1, 12'hF00, tag);
            end
        end
    endtask

    task automatic run_to(input int target);
        int budget = 4000;
        while (n_ticks < target && budget > 0) begin
            end_frame();
            budget--;
        end
        if (n_ticks != target) begin
            errors++;
            $display("FAIL run_to: observed ticks %0d required %0d", n_ticks, target);
        end
    endtask

    initial begin
        reset = 1; pos_x = '0; pos_y = '0; video_on_in = 0; h_sync_in = 1; v_sync_in = 1;
        pattern_sel = '0; color = '0;
        @(negedge clk);

        // Reset held three cycles while inputs toggle
        for (int i = 0; i < 3; i++)
            step(1, HA - 1, VA - 1, 1, 0, 0, $urandom_range(3), 12'($urandom), "reset");
        probe_box("box_origin");

        // Bars
        step(0, 0,   5, 1, 1, 1, 0, 12'h000, "bar0");
        step(0, 80,  5, 1, 0, 1, 0, 12'h000, "bar80");
        step(0, 559, 5, 1, 1, 0, 0, 12'h000, "bar559");
        step(0, 639, 5, 1, 1, 1, 0, 12'h000, "bar639");

        // Checker and blanking
        step(0, 32, 0,  1, 1, 1, 2, 12'h000, "chk32_0");
        step(0, 32, 32, 1, 1, 1, 2, 12'h000, "chk32_32");
        for (int p = 0; p < 4; p++) step(0, 40, 40, 0, 0, 0, p, 12'hABC, "blank_pat");

        // Box: frame 1 then one tick
        step(0, 0,  0, 1, 1, 1, 1, 12'hF00, "box1_00");
        step(0, 32, 0, 1, 1, 1, 1, 12'hF00, "box1_32");
        end_frame();
        step(0, 0, 0, 1, 1, 1, 1, 12'hF00, "box2_00");
        step(0, 1, 1, 1, 1, 1, 1, 12'hF00, "box2_11");

        for (int i = 0; i < 200; i++) rand_pixel("rand");

        // Mid-frame reset with the box at (100,100)
        run_to(100);
        probe_box("box100");
        for (int i = 0; i < 5; i++) rand_pixel("mid");
        step(1, 200, 200, 1, 1, 1, 1, 12'hF00, "midreset");
        probe_box("after_reset");
        for (int i = 0; i < 20; i++) rand_pixel("post_reset");
        run_to(1);
        probe_box("post_reset_tick");

        // Vertical bounce then horizontal bounce
        run_to(448);
        probe_box("y448");
        run_to(449);
        probe_box("y447");
        run_to(608);
        probe_box("x608");
        run_to(609);
        probe_box("x607");
        for (int i = 0; i < 100; i++) rand_pixel("rand_tail");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
